// File: rtl/config_stream_loader.sv
// Configuration-bus initiator: parses a header/ADDR/DATA/checksum word stream
// and issues one-cycle config writes, each followed by a programmable quiet gap.
module config_stream_loader #(
  parameter logic [15:0] MAGIC      = 16'hC0F1,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        config_write,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] write_count
);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    ADDR,
    DATA,
    ISSUE,
    GAP,
    CHK
  } state_t;

  localparam logic [15:0] GAP_LOAD = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : '0;

  state_t      state;
  logic [15:0] n_pairs;
  logic [15:0] gap_cnt;
  logic [31:0] addr_hold;
  logic [31:0] csum;
  logic        last_pair;
  logic        xfer;

  assign in_ready     = (state == HDR) || (state == ADDR) || (state == DATA) || (state == CHK);
  assign busy         = (state != IDLE);
  assign config_write = (state == ISSUE);
  assign xfer         = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      n_pairs     <= '0;
      gap_cnt     <= '0;
      addr_hold   <= '0;
      csum        <= '0;
      last_pair   <= 1'b0;
      config_addr <= '0;
      config_data <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
      write_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            done        <= 1'b0;
            error       <= 1'b0;
            write_count <= '0;
            csum        <= '0;
            state       <= HDR;
          end
        end
        HDR: begin
          if (xfer) begin
            if (in_data[31:16] != MAGIC) begin
              error <= 1'b1;
              state <= IDLE;
            end else begin
              n_pairs <= in_data[15:0];
              state   <= (in_data[15:0] == 16'd0) ? CHK : ADDR;
            end
          end
        end
        ADDR: begin
          if (xfer) begin
            addr_hold <= in_data;
            csum      <= csum ^ in_data;
            state     <= DATA;
          end
        end
        DATA: begin
          if (xfer) begin
            csum        <= csum ^ in_data;
            config_addr <= addr_hold;
            config_data <= in_data;
            // Decided one cycle early so ISSUE/GAP can route without an adder.
            last_pair   <= (16'(write_count + 16'd1) == n_pairs);
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          write_count <= write_count + 16'd1;
          if (GAP_CYCLES > 0) begin
            gap_cnt <= GAP_LOAD;
            state   <= GAP;
          end else begin
            state <= last_pair ? CHK : ADDR;
          end
        end
        GAP: begin
          if (gap_cnt == 16'd0) begin
            state <= last_pair ? CHK : ADDR;
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end
        CHK: begin
          if (xfer) begin
            if (in_data == csum) begin
              done <= 1'b1;
            end else begin
              error <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_config_stream_loader.sv
// Scoreboard bench for config_stream_loader: expected write pairs are queued as
// DATA words are driven and checked against each config_write strobe.
module tb_config_stream_loader;

  localparam int unsigned GAP = 2;
  localparam logic [15:0] MAG = 16'hC0F1;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } pair_t;

  localparam pair_t P0 = {32'h0003_0001, 32'h0000_00AA};
  localparam pair_t P1 = {32'h0005_0002, 32'h0000_0055};
  localparam logic [31:0] GOOD_CSUM = 32'h0006_00FC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] config_addr;
  logic [31:0] config_data;
  logic        config_write;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] write_count;

  config_stream_loader #(
    .MAGIC     (MAG),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .config_addr (config_addr),
    .config_data (config_data),
    .config_write(config_write),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .write_count (write_count)
  );

  always #5 clk = ~clk;

  int    n_vec = 0;
  int    n_miss = 0;
  int    cycle = 0;
  int    last_data_cycle = 0;
  int    n_strobes = 0;
  int    gap_chk = 0;
  pair_t sb[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cycle++;

  // Monitor: strobe contents/latency, quiet gap length, done/error exclusivity.
  always @(negedge clk) begin
    pair_t p;
    check_val("done_err_excl", {31'b0, done & error}, 32'd0);
    if (reset) begin
      gap_chk = 0;
    end else if (gap_chk > 1) begin
      check_val("gap_in_ready", {31'b0, in_ready}, 32'd0);
      check_val("gap_busy", {31'b0, busy}, 32'd1);
      gap_chk--;
    end else if (gap_chk == 1) begin
      check_val("post_gap_in_ready", {31'b0, in_ready}, 32'd1);
      gap_chk = 0;
    end
    if (config_write) begin
      n_strobes++;
      check_val("issue_in_ready", {31'b0, in_ready}, 32'd0);
      check_val("strobe_vs_data_edge", 32'(cycle - last_data_cycle), 32'd0);
      check_val("sb_depth", 32'(sb.size()), 32'd1);
      if (sb.size() > 0) begin
        p = sb.pop_front();
        check_val("strobe_addr", config_addr, p.a);
        check_val("strobe_data", config_data, p.d);
      end
      gap_chk = GAP + 1;
    end
  end

  task automatic send(input logic [31:0] w, input bit rnd);
    bit sent;
    sent = 1'b0;
    for (int i = 0; i < 200 && !sent; i++) begin
      @(negedge clk);
      if (rnd && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data  = $urandom;
      end else begin
        in_valid = 1'b1;
        in_data  = w;
        if (in_ready) begin
          @(posedge clk);
          #1;
          in_valid = 1'b0;
          sent = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
    check_val("word_accepted", {31'b0, sent}, 32'd1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_pair(input pair_t p, input bit rnd);
    send(p.a, rnd);
    sb.push_back(p);
    send(p.d, rnd);
    last_data_cycle = cycle;
  endtask

  task automatic load(input logic [15:0] magic, input int n, input logic [31:0] csum, input bit rnd);
    pulse_start();
    send({magic, 16'(n)}, rnd);
    if (magic == MAG) begin
      if (n > 0) send_pair(P0, rnd);
      if (n > 1) send_pair(P1, rnd);
      send(csum, rnd);
    end
  endtask

  task automatic expect_result(input string tag, input logic exp_done, input logic exp_err,
                               input logic [15:0] exp_wc, input int exp_strobes);
    @(negedge clk);
    check_val({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check_val({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
    check_val({tag, "_done"}, {31'b0, done}, {31'b0, exp_done});
    check_val({tag, "_error"}, {31'b0, error}, {31'b0, exp_err});
    check_val({tag, "_write_count"}, {16'b0, write_count}, {16'b0, exp_wc});
    check_val({tag, "_strobes"}, 32'(n_strobes), 32'(exp_strobes));
    check_val({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check_val({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
    check_val({tag, "_cfg_write"}, {31'b0, config_write}, 32'd0);
    check_val({tag, "_cfg_addr"}, config_addr, 32'd0);
    check_val({tag, "_cfg_data"}, config_data, 32'd0);
    check_val({tag, "_done"}, {31'b0, done}, 32'd0);
    check_val({tag, "_error"}, {31'b0, error}, 32'd0);
    check_val({tag, "_write_count"}, {16'b0, write_count}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // 1: nominal two-pair load
    n_strobes = 0;
    load(MAG, 2, GOOD_CSUM, 1'b0);
    expect_result("nominal", 1'b1, 1'b0, 16'd2, 2);
    check_val("hold_addr", config_addr, P1.a);
    check_val("hold_data", config_data, P1.d);

    // 2: bad magic
    n_strobes = 0;
    load(16'hDEAD, 1, 32'd0, 1'b0);
    expect_result("bad_magic", 1'b0, 1'b1, 16'd0, 0);

    // 3: checksum mismatch after both writes
    n_strobes = 0;
    load(MAG, 2, 32'd0, 1'b0);
    expect_result("bad_csum", 1'b0, 1'b1, 16'd2, 2);

    // 4: empty load, then immediate restart with wrong checksum
    n_strobes = 0;
    load(MAG, 0, 32'd0, 1'b0);
    expect_result("n0_good", 1'b1, 1'b0, 16'd0, 0);
    pulse_start();
    check_val("restart_done_cleared", {31'b0, done}, 32'd0);
    check_val("restart_busy", {31'b0, busy}, 32'd1);
    send({MAG, 16'd0}, 1'b0);
    send(32'd1, 1'b0);
    expect_result("n0_bad", 1'b0, 1'b1, 16'd0, 0);

    // 5: random valid gaps plus a stray start mid-load
    n_strobes = 0;
    fork
      load(MAG, 2, GOOD_CSUM, 1'b1);
      begin
        repeat (8) @(negedge clk);
        check_val("busy_at_stray_start", {31'b0, busy}, 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    expect_result("backpressure", 1'b1, 1'b0, 16'd2, 2);

    // 6: asynchronous reset during the gap after the first strobe
    n_strobes = 0;
    pulse_start();
    send({MAG, 16'd2}, 1'b0);
    send_pair(P0, 1'b0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_all_zero("mid_reset");
    check_val("mid_reset_strobes", 32'(n_strobes), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_strobes = 0;
    load(MAG, 2, GOOD_CSUM, 1'b0);
    expect_result("after_reset", 1'b1, 1'b0, 16'd2, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
